// File: rtl/lt_serial_pkg.sv
// Shared types and helpers for the serial unsigned less-than sequencer.
package lt_serial_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Counter width for n steps, never narrower than one bit.
  function automatic int clog2w(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/lt_uint_serial_seq_if.sv
// Operand/result handshake bundle for the serial less-than sequencer.
interface lt_uint_serial_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic             Y;
  logic             busy;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, Y, busy
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, Y, busy
  );
endinterface

// File: rtl/lt_digit_step.sv
// Combinational DIGIT-bit borrow chain, LSB to MSB.
module lt_digit_step #(
  parameter int DIGIT     = 1,
  parameter int IMPL_TYPE = 0
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bi,
  output logic             bo
);
  logic [DIGIT:0] c;

  assign c[0] = bi;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    subtractor_1bit_cmp #(
      .IMPL_TYPE(IMPL_TYPE)
    ) u_cell (
      .a (a[i]),
      .b (b[i]),
      .bi(c[i]),
      .bo(c[i+1])
    );
  end

  assign bo = c[DIGIT];
endmodule

// File: rtl/subtractor_1bit_cmp.sv
// One-bit borrow cell: borrow-out of a - b - bi.
module subtractor_1bit_cmp #(
  parameter int IMPL_TYPE = 0
) (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic bo
);
  if (IMPL_TYPE == 0) begin : g_sop
    assign bo = (~a & b) | (~(a ^ b) & bi);
  end else begin : g_mux
    // Differing bits decide on their own; equal bits pass the borrow.
    assign bo = (a ^ b) ? b : bi;
  end
endmodule

// File: rtl/lt_uint_serial_seq.sv
// Multi-cycle unsigned A<B compare, DIGIT bits per cycle, LSB first.
module lt_uint_serial_seq
  import lt_serial_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DIGIT     = 1,
  parameter int IMPL_TYPE = 0
) (
  input logic                       clk,
  input logic                       rst,
  lt_uint_serial_seq_if.slave       bus
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = clog2w(STEPS);

  if ((WIDTH % DIGIT) != 0) begin : g_chk
    $fatal(1, "WIDTH must be a multiple of DIGIT");
  end

  state_e           state_q;
  state_e           state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             borrow_q;
  logic             y_q;
  logic             step_bo;
  logic             cnt_last;
  logic             accept;

  lt_digit_step #(
    .DIGIT    (DIGIT),
    .IMPL_TYPE(IMPL_TYPE)
  ) u_step (
    .a (a_sh[DIGIT-1:0]),
    .b (b_sh[DIGIT-1:0]),
    .bi(borrow_q),
    .bo(step_bo)
  );

  assign cnt_last = (cnt_q == CW'(STEPS - 1));
  assign accept   = (state_q == S_IDLE) && bus.in_valid;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.in_valid)  state_d = S_RUN;
      S_RUN:   if (cnt_last)      state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      borrow_q <= 1'b0;
      y_q      <= 1'b0;
    end else if (accept) begin
      cnt_q    <= '0;
      a_sh     <= bus.A;
      b_sh     <= bus.B;
      borrow_q <= 1'b0;
    end else if (state_q == S_RUN) begin
      cnt_q    <= cnt_q + 1'b1;
      a_sh     <= a_sh >> DIGIT;
      b_sh     <= b_sh >> DIGIT;
      borrow_q <= step_bo;
      if (cnt_last) y_q <= step_bo;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.Y         = y_q;
endmodule

// File: tb/tb_lt_uint_serial_seq.sv
// Directed bench for lt_uint_serial_seq at DIGIT=1, 4 and 16.
module tb_lt_uint_serial_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         drv_valid = 1'b0;
  logic [W-1:0] drv_a = '0;
  logic [W-1:0] drv_b = '0;
  logic         drv_ordy = 1'b1;
  int           sel = 0;

  int total = 0;
  int bad   = 0;

  logic o_ir, o_ov, o_y, o_busy;

  always #5 clk = ~clk;

  lt_uint_serial_seq_if #(.WIDTH(W)) if1 ();
  lt_uint_serial_seq_if #(.WIDTH(W)) if4 ();
  lt_uint_serial_seq_if #(.WIDTH(W)) if16 ();

  assign if1.in_valid   = drv_valid && (sel == 0);
  assign if4.in_valid   = drv_valid && (sel == 1);
  assign if16.in_valid  = drv_valid && (sel == 2);
  assign if1.A = drv_a;
  assign if1.B = drv_b;
  assign if4.A = drv_a;
  assign if4.B = drv_b;
  assign if16.A = drv_a;
  assign if16.B = drv_b;
  assign if1.out_ready  = drv_ordy;
  assign if4.out_ready  = drv_ordy;
  assign if16.out_ready = drv_ordy;

  lt_uint_serial_seq #(.WIDTH(W), .DIGIT(1), .IMPL_TYPE(0))
    u_d1 (.clk(clk), .rst(rst), .bus(if1));
  lt_uint_serial_seq #(.WIDTH(W), .DIGIT(4), .IMPL_TYPE(1))
    u_d4 (.clk(clk), .rst(rst), .bus(if4));
  lt_uint_serial_seq #(.WIDTH(W), .DIGIT(16), .IMPL_TYPE(0))
    u_d16 (.clk(clk), .rst(rst), .bus(if16));

  always_comb begin
    o_ir   = if1.in_ready;
    o_ov   = if1.out_valid;
    o_y    = if1.Y;
    o_busy = if1.busy;
    if (sel == 1) begin
      o_ir   = if4.in_ready;
      o_ov   = if4.out_valid;
      o_y    = if4.Y;
      o_busy = if4.busy;
    end else if (sel == 2) begin
      o_ir   = if16.in_ready;
      o_ov   = if16.out_valid;
      o_y    = if16.Y;
      o_busy = if16.busy;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accepts one op, waits for out_valid, checks latency/Y, then handoff.
  task automatic run_op(input string tag, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int exp_y,
                        input int exp_lat);
    int n;
    drv_a     = a;
    drv_b     = b;
    drv_valid = 1'b1;
    tick();
    drv_valid = 1'b0;
    drv_a     = ~a;
    drv_b     = b ^ 16'h5A5A;
    n = 1;
    while (!o_ov && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_y"}, int'(o_y), exp_y);
    tick();
    chk({tag, "_rdy"}, int'(o_ir), 1);
  endtask

  initial begin
    int n;
    int seen;
    logic [W-1:0] ra, rb;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ov", int'(o_ov), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_ir", int'(o_ir), 1);
    chk("rst_y", int'(o_y), 0);

    run_op("t1", 16'd3, 16'd5, 1, 17);
    run_op("eq_ff", 16'hFFFF, 16'hFFFF, 0, 17);
    run_op("eq_00", 16'h0000, 16'h0000, 0, 17);
    run_op("msb_a", 16'h8000, 16'h7FFF, 0, 17);
    run_op("msb_b", 16'h7FFF, 16'h8000, 1, 17);
    run_op("one_zero", 16'h0001, 16'h0000, 0, 17);
    run_op("zero_max", 16'h0000, 16'hFFFF, 1, 17);

    // Back-pressure: hold out_ready low and poke in_valid.
    drv_ordy  = 1'b0;
    drv_a     = 16'h1234;
    drv_b     = 16'h1235;
    drv_valid = 1'b1;
    tick();
    drv_valid = 1'b0;
    n = 1;
    while (!o_ov && n < 100) begin
      tick();
      n++;
    end
    chk("bp_lat", n, 17);
    for (int i = 0; i < 5; i++) begin
      drv_valid = 1'b1;
      drv_a     = 16'hFFFF;
      drv_b     = 16'h0000;
      tick();
      chk("bp_ov", int'(o_ov), 1);
      chk("bp_y", int'(o_y), 1);
      chk("bp_ir", int'(o_ir), 0);
    end
    drv_valid = 1'b0;
    drv_ordy  = 1'b1;
    tick();
    chk("bp_rel_ov", int'(o_ov), 0);
    chk("bp_rel_ir", int'(o_ir), 1);
    chk("bp_rel_y", int'(o_y), 1);

    // Reset in the middle of RUN.
    drv_a     = 16'h0005;
    drv_b     = 16'h0003;
    drv_valid = 1'b1;
    tick();
    drv_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("mid_busy", int'(o_busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_busy0", int'(o_busy), 0);
    chk("mid_ir", int'(o_ir), 1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_ov) seen++;
      tick();
    end
    chk("mid_no_ov", seen, 0);
    run_op("post_rst", 16'h0000, 16'h0001, 1, 17);

    sel = 1;
    tick();
    run_op("d4_dir", 16'h7FFF, 16'h8000, 1, 5);
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(7) == 0) ? ra : W'($urandom);
      run_op("d4_rnd", ra, rb, int'(ra < rb), 5);
    end

    sel = 2;
    tick();
    run_op("d16_dir", 16'h8000, 16'h7FFF, 0, 2);
    run_op("d16_eq", 16'hABCD, 16'hABCD, 0, 2);
    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(7) == 0) ? ra : W'($urandom);
      run_op("d16_rnd", ra, rb, int'(ra < rb), 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
